sm_muldiv: RTL



---
 rtl/sm_muldiv_pkg.sv | 29 ++
 rtl/sm_muldiv_step.sv | 33 +++
 rtl/sm_muldiv.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide unit.
// FSM states, 2-bit op codes and the SPECIAL funct codes decoded by control.
package sm_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIN  = 2'd2
    } md_state_t;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Ports: acc (2*WIDTH working reg), opnd (multiplicand/divisor), div (mode), nxt.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               div,
    output logic [2*WIDTH-1:0] nxt
);

    // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: acc = {remainder, dividend bits}; shift one bit in, trial subtract.
    // The remainder stays below the divisor, so WIDTH bits hold the difference.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    assign rem_sh = acc[2*WIDTH-1:WIDTH-1];
    assign ge     = rem_sh >= {1'b0, opnd};
    assign diff   = rem_sh[WIDTH-1:0] - opnd;

    always_comb begin
        nxt = {sum, acc[WIDTH-1:1]};
        if (div) begin
            nxt = {(ge ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports: start/op/srcA/srcB launch, cancel aborts, hi_we/lo_we/wd for MTHI/MTLO, busy/done/hi/lo.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state;
    md_state_t          state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;

    logic               go;
    logic               sgn;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign go     = start & ~cancel;
    assign sgn    = SIGNED_EN & op[0];
    assign sign_a = sgn & srcA[WIDTH-1];
    assign sign_b = sgn & srcB[WIDTH-1];
    assign mag_a  = sign_a ? -srcA : srcA;
    assign mag_b  = sign_b ? -srcB : srcB;

    assign prod = neg_res ? -acc : acc;
    assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    sm_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc  (acc),
        .opnd (opnd),
        .div  (is_div),
        .nxt  (acc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: if (go) state_nxt = MD_CALC;
            MD_CALC: begin
                if (cancel)         state_nxt = MD_IDLE;
                else if (cnt == '0) state_nxt = MD_FIN;
            end
            MD_FIN:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != MD_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (go) begin
                        is_div  <= op_is_div(op);
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        a_raw   <= srcA;
                        cnt     <= CW'(WIDTH - 1);
                        if (op_is_div(op)) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                MD_CALC: begin
                    if (!cancel) begin
                        acc <= acc_nxt;
                        if (cnt != '0) cnt <= cnt - 1'b1;
                    end
                end
                MD_FIN: begin
                    if (!cancel) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= prod;
                        end else if (opnd == '0) begin
                            // Divide by zero reports the raw dividend in HI.
                            lo <= '1;
                            hi <= a_raw;
                        end else begin
                            lo <= quo;
                            hi <= rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
